// File: rtl/nonce_sched_pkg.sv
// Shared types and helpers for the nonce scheduler: FSM state encoding,
// default blob geometry and the round-robin pointer step.
package nonce_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARB   = 2'd1,
        S_ISSUE = 2'd2
    } sched_state_t;

    localparam int BLOB_WIDTH_DEF = 2144;
    localparam int BLOB_BYTES     = BLOB_WIDTH_DEF / 8;

    // Pointer position that follows a grant to core idx, circular over n cores.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/nonce_scheduler_if.sv
// Job intake, core request and blob issue signals of the nonce scheduler.
// master = host/cores/downstream side, slave = scheduler side.
interface nonce_sched_if #(
    parameter int CORE_COUNT  = 8,
    parameter int BLOB_WIDTH  = 2144,
    parameter int NONCE_WIDTH = 32,
    parameter int COUNT_WIDTH = 32
);
    logic                   job_valid;
    logic                   job_ready;
    logic [BLOB_WIDTH-1:0]  job_blob;
    logic [NONCE_WIDTH-1:0] job_start_nonce;
    logic [COUNT_WIDTH-1:0] job_count;
    logic [CORE_COUNT-1:0]  core_req;
    logic                   blob_valid;
    logic                   blob_ready;
    logic [BLOB_WIDTH-1:0]  blob_data;
    logic [NONCE_WIDTH-1:0] blob_nonce;
    logic [CORE_COUNT-1:0]  blob_core_oh;

    modport master (
        output job_valid, job_blob, job_start_nonce, job_count, core_req, blob_ready,
        input  job_ready, blob_valid, blob_data, blob_nonce, blob_core_oh
    );

    modport slave (
        input  job_valid, job_blob, job_start_nonce, job_count, core_req, blob_ready,
        output job_ready, blob_valid, blob_data, blob_nonce, blob_core_oh
    );
endinterface

// File: rtl/nonce_insert.sv
// Combinational blob formatter: reverses byte order, then splices the nonce
// into bits [NONCE_POS*8 +: NONCE_WIDTH] of the reversed blob.
module nonce_insert #(
    parameter int BLOB_WIDTH  = 2144,
    parameter int NONCE_WIDTH = 32,
    parameter int NONCE_POS   = 39
) (
    input  logic [BLOB_WIDTH-1:0]  i_blob,
    input  logic [NONCE_WIDTH-1:0] i_nonce,
    output logic [BLOB_WIDTH-1:0]  o_blob
);
    localparam int NB = BLOB_WIDTH / 8;

    always_comb begin
        o_blob = '0;
        for (int i = 0; i < NB; i++) begin
            o_blob[(NB-1-i)*8 +: 8] = i_blob[i*8 +: 8];
        end
        o_blob[NONCE_POS*8 +: NONCE_WIDTH] = i_nonce;
    end
endmodule

// File: rtl/nonce_scheduler.sv
// Bounded, preemptible nonce scheduler: one job at a time, round-robin grants
// to requesting cores, one registered blob issue per grant.
// Optional statistics counters are built when NONCE_SCHED_STATS_EN is defined.
module nonce_scheduler
    import nonce_sched_pkg::*;
#(
    parameter int CORE_COUNT  = 8,
    parameter int BLOB_WIDTH  = BLOB_BYTES * 8,
    parameter int NONCE_WIDTH = 32,
    parameter int NONCE_POS   = 39,
    parameter int COUNT_WIDTH = 32
) (
    input  logic               aclk,
    input  logic               rst_n,
    nonce_sched_if.slave       bus,
    output logic               busy,
    output logic               done,
    output logic [31:0]        stat_issued,
    output logic [31:0]        stat_stall
);
    localparam int IDX_W = $clog2(CORE_COUNT);

    sched_state_t           r_state;
    logic [BLOB_WIDTH-1:0]  r_blob;
    logic [NONCE_WIDTH-1:0] r_nonce;
    logic [COUNT_WIDTH-1:0] r_rem;
    logic [IDX_W-1:0]       r_rr;
    logic [IDX_W-1:0]       r_gnt;
    logic                   r_blob_valid;
    logic [BLOB_WIDTH-1:0]  r_blob_data;
    logic [NONCE_WIDTH-1:0] r_blob_nonce;
    logic [CORE_COUNT-1:0]  r_blob_oh;
    logic                   r_done;

    logic                   w_gnt_found;
    logic [IDX_W-1:0]       w_gnt_idx;
    logic [CORE_COUNT-1:0]  w_gnt_oh;
    logic [BLOB_WIDTH-1:0]  w_ins_blob;
    logic                   w_hs;

    nonce_insert #(
        .BLOB_WIDTH (BLOB_WIDTH),
        .NONCE_WIDTH(NONCE_WIDTH),
        .NONCE_POS  (NONCE_POS)
    ) u_insert (
        .i_blob (r_blob),
        .i_nonce(r_nonce),
        .o_blob (w_ins_blob)
    );

    // First requester at or after the rr pointer, searching circularly.
    always_comb begin
        int j;
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_gnt_oh    = '0;
        j           = 0;
        for (int k = 0; k < CORE_COUNT; k++) begin
            j = int'(r_rr) + k;
            if (j >= CORE_COUNT) j = j - CORE_COUNT;
            if (!w_gnt_found && bus.core_req[IDX_W'(j)]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = IDX_W'(j);
            end
        end
        w_gnt_oh[w_gnt_idx] = w_gnt_found;
    end

    assign w_hs = r_blob_valid & bus.blob_ready;

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_blob       <= '0;
            r_nonce      <= '0;
            r_rem        <= '0;
            r_rr         <= '0;
            r_gnt        <= '0;
            r_blob_valid <= 1'b0;
            r_blob_data  <= '0;
            r_blob_nonce <= '0;
            r_blob_oh    <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.job_valid) begin
                        r_blob  <= bus.job_blob;
                        r_nonce <= bus.job_start_nonce;
                        r_rem   <= bus.job_count;
                        r_state <= S_ARB;
                    end
                end
                S_ARB: begin
                    // A new job offer preempts both completion and granting.
                    if (bus.job_valid) begin
                        r_blob  <= bus.job_blob;
                        r_nonce <= bus.job_start_nonce;
                        r_rem   <= bus.job_count;
                    end else if (r_rem == '0) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else if (w_gnt_found) begin
                        r_blob_data  <= w_ins_blob;
                        r_blob_nonce <= r_nonce;
                        r_blob_oh    <= w_gnt_oh;
                        r_gnt        <= w_gnt_idx;
                        r_blob_valid <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (w_hs) begin
                        r_blob_valid <= 1'b0;
                        r_nonce      <= r_nonce + NONCE_WIDTH'(1);
                        if (r_rem != '0) r_rem <= r_rem - COUNT_WIDTH'(1);
                        r_rr         <= IDX_W'(rr_next(int'(r_gnt), CORE_COUNT));
                        r_state      <= S_ARB;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.job_ready    = (r_state != S_ISSUE);
    assign bus.blob_valid   = r_blob_valid;
    assign bus.blob_data    = r_blob_data;
    assign bus.blob_nonce   = r_blob_nonce;
    assign bus.blob_core_oh = r_blob_oh;
    assign busy             = (r_state != S_IDLE);
    assign done             = r_done;

`ifdef NONCE_SCHED_STATS_EN
    logic [31:0] r_stat_issued;
    logic [31:0] r_stat_stall;

    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_issued <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (w_hs && (r_stat_issued != '1)) r_stat_issued <= r_stat_issued + 32'd1;
            if (r_blob_valid && !bus.blob_ready && (r_stat_stall != '1))
                r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign stat_issued = r_stat_issued;
    assign stat_stall  = r_stat_stall;
`else
    assign stat_issued = '0;
    assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench for nonce_scheduler with a job-level reference model checked every cycle.
module tb_nonce_scheduler;
    localparam int CC = 8;
    localparam int BW = 2144;
    localparam int NW = 32;
    localparam int NP = 39;
    localparam int CW = 32;
    localparam int IW = $clog2(CC);

    logic        aclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy, done;
    logic [31:0] stat_issued, stat_stall;

    nonce_sched_if #(.CORE_COUNT(CC), .BLOB_WIDTH(BW), .NONCE_WIDTH(NW), .COUNT_WIDTH(CW)) bus ();

    nonce_scheduler #(
        .CORE_COUNT(CC), .BLOB_WIDTH(BW), .NONCE_WIDTH(NW), .NONCE_POS(NP), .COUNT_WIDTH(CW)
    ) dut (
        .aclk(aclk), .rst_n(rst_n), .bus(bus), .busy(busy), .done(done),
        .stat_issued(stat_issued), .stat_stall(stat_stall)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_data(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        int bad;
        checks++;
        if (act !== exp) begin
            errors++;
            bad = 0;
            for (int i = BW/8 - 1; i >= 0; i--) if (act[i*8 +: 8] !== exp[i*8 +: 8]) bad = i;
            $display("FAIL %s byte %0d actual=0x%0h required=0x%0h", name, bad,
                     act[bad*8 +: 8], exp[bad*8 +: 8]);
        end
    endtask

    function automatic logic [BW-1:0] exp_blob(input logic [BW-1:0] b, input logic [NW-1:0] n);
        logic [BW-1:0] r;
        r = {<<8{b}};
        r[NP*8 +: NW] = n;
        return r;
    endfunction

    function automatic logic [BW-1:0] pattern(input int mul, input int add);
        logic [BW-1:0] b;
        for (int i = 0; i < BW/8; i++) b[i*8 +: 8] = 8'(i*mul + add);
        return b;
    endfunction

    // ---------------- reference model and per-cycle compare ----------------
    bit              chk_en = 1'b0;
    bit              m_active;
    logic [NW-1:0]   m_nonce;
    logic [CW-1:0]   m_rem;
    logic [BW-1:0]   m_blob;
    int              m_ptr;
    bit              prev_valid;
    logic [CC-1:0]   prev_req;
    int              e_core;
    logic [CC-1:0]   e_oh;
    logic [NW-1:0]   e_nonce;
    logic [BW-1:0]   e_data;
    int              done_cnt;
    logic [NW-1:0]   log_nonce[$];
    logic [CC-1:0]   log_oh[$];
    logic [BW-1:0]   log_data[$];

    always @(negedge aclk) begin
        if (!chk_en) begin
            m_active   = 1'b0;
            m_ptr      = 0;
            m_rem      = '0;
            prev_valid = 1'b0;
            prev_req   = bus.core_req;
        end else begin
            if (done === 1'b1) begin
                check("done_only_when_exhausted", 64'(m_active && m_rem == '0), 64'd1);
                done_cnt++;
                m_active = 1'b0;
            end
            check("busy", 64'(busy), 64'(m_active));
            check("job_ready", 64'(bus.job_ready), 64'(!bus.blob_valid));
            if (bus.blob_valid === 1'b1) begin
                if (!prev_valid) begin
                    e_core = -1;
                    for (int k = CC - 1; k >= 0; k--)
                        if (prev_req[IW'((m_ptr + k) % CC)]) e_core = (m_ptr + k) % CC;
                    check("grant_had_request", 64'(e_core >= 0), 64'd1);
                    check("issue_allowed", 64'(m_active && m_rem != '0), 64'd1);
                    e_oh = '0;
                    if (e_core >= 0) e_oh[IW'(e_core)] = 1'b1;
                    e_nonce = m_nonce;
                    e_data  = exp_blob(m_blob, m_nonce);
                end
                check("blob_core_oh", 64'(bus.blob_core_oh), 64'(e_oh));
                check("blob_nonce", 64'(bus.blob_nonce), 64'(e_nonce));
                check_data("blob_data", bus.blob_data, e_data);
                if (bus.blob_ready === 1'b1) begin
                    log_nonce.push_back(bus.blob_nonce);
                    log_oh.push_back(bus.blob_core_oh);
                    log_data.push_back(bus.blob_data);
                    m_nonce = m_nonce + 1;
                    m_rem   = m_rem - 1;
                    m_ptr   = (e_core + 1) % CC;
                end
            end
            if (bus.job_valid && bus.job_ready) begin
                m_blob   = bus.job_blob;
                m_nonce  = bus.job_start_nonce;
                m_rem    = bus.job_count;
                m_active = 1'b1;
            end
            prev_valid = bus.blob_valid;
            prev_req   = bus.core_req;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic apply_reset();
        @(posedge aclk); #1;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        bus.job_valid = 1'b0; bus.core_req = '0; bus.blob_ready = 1'b0;
        repeat (2) @(posedge aclk);
        #1 rst_n = 1'b1;
        log_nonce.delete(); log_oh.delete(); log_data.delete();
        done_cnt = 0;
        chk_en   = 1'b1;
    endtask

    task automatic offer_job(input logic [BW-1:0] b, input logic [NW-1:0] s, input logic [CW-1:0] c);
        bit got;
        @(posedge aclk); #1;
        bus.job_blob = b; bus.job_start_nonce = s; bus.job_count = c; bus.job_valid = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge aclk);
            if (bus.job_ready === 1'b1) got = 1'b1;
        end
        check("job_accept_timeout", 64'(got), 64'd1);
        @(posedge aclk); #1 bus.job_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit got = 1'b0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge aclk);
            if (done === 1'b1) got = 1'b1;
        end
        check(name, 64'(got), 64'd1);
    endtask

    task automatic wait_valid(input string name);
        bit got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge aclk);
            if (bus.blob_valid === 1'b1) got = 1'b1;
        end
        check(name, 64'(got), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        logic [BW-1:0] d;
        logic [BW-1:0] snap_data;
        bus.job_valid = 1'b0; bus.job_blob = '0; bus.job_start_nonce = '0; bus.job_count = '0;
        bus.core_req = '0; bus.blob_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge aclk);
        #1;
        check("rst_blob_valid", 64'(bus.blob_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_job_ready", 64'(bus.job_ready), 64'd1);
        check("rst_blob_nonce", 64'(bus.blob_nonce), 64'd0);
        check("rst_core_oh", 64'(bus.blob_core_oh), 64'd0);
        check_data("rst_blob_data", bus.blob_data, '0);
        check("rst_stat_issued", 64'(stat_issued), 64'd0);
        check("rst_stat_stall", 64'(stat_stall), 64'd0);
        apply_reset();

        // Basic round-robin: cores 0 and 2 requesting
        bus.core_req = 8'b0000_0101; bus.blob_ready = 1'b1;
        offer_job(pattern(7, 3), 32'h10, 32'd3);
        wait_done("rr_done_seen");
        @(negedge aclk);
        check("rr_busy_after", 64'(busy), 64'd0);
        check("rr_done_single", 64'(done), 64'd0);
        check("rr_count", 64'(log_nonce.size()), 64'd3);
        if (log_nonce.size() == 3) begin
            check("rr_core0", 64'(log_oh[0]), 64'h01);
            check("rr_nonce0", 64'(log_nonce[0]), 64'h10);
            check("rr_core1", 64'(log_oh[1]), 64'h04);
            check("rr_nonce1", 64'(log_nonce[1]), 64'h11);
            check("rr_core2", 64'(log_oh[2]), 64'h01);
            check("rr_nonce2", 64'(log_nonce[2]), 64'h12);
        end
        check("rr_done_count", 64'(done_cnt), 64'd1);

        // Nonce wrap and literal blob layout
        apply_reset();
        bus.core_req = 8'b0000_0001; bus.blob_ready = 1'b1;
        offer_job(pattern(1, 0), 32'hFFFF_FFFF, 32'd2);
        wait_done("wrap_done_seen");
        check("wrap_count", 64'(log_nonce.size()), 64'd2);
        if (log_data.size() == 2) begin
            d = log_data[0];
            check("wrap_field0", 64'(d[312 +: 32]), 64'hFFFF_FFFF);
            d = log_data[1];
            check("wrap_field1", 64'(d[312 +: 32]), 64'h0);
            check("wrap_nonce1", 64'(log_nonce[1]), 64'h0);
            check("rev_low_byte", 64'(d[7:0]), 64'h0B);
            check("rev_top_byte", 64'(d[2143:2136]), 64'h00);
            check("rev_second_byte", 64'(d[2135:2128]), 64'h01);
            check("rev_below_nonce", 64'(d[311:304]), 64'hE5);
            check("rev_above_nonce", 64'(d[351:344]), 64'hE0);
        end

        // Backpressure: five stall cycles with the request withdrawn
        apply_reset();
        bus.core_req = 8'b0000_1000; bus.blob_ready = 1'b0;
        offer_job(pattern(3, 1), 32'h50, 32'd1);
        wait_valid("bp_valid_seen");
        check("bp_nonce", 64'(bus.blob_nonce), 64'h50);
        check("bp_core", 64'(bus.blob_core_oh), 64'h08);
        snap_data = bus.blob_data;
        @(posedge aclk); #1 bus.core_req = '0;
        repeat (4) begin
            @(negedge aclk);
            check("bp_hold_nonce", 64'(bus.blob_nonce), 64'h50);
            check("bp_hold_core", 64'(bus.blob_core_oh), 64'h08);
            check_data("bp_hold_data", bus.blob_data, snap_data);
        end
        @(posedge aclk); #1 bus.blob_ready = 1'b1;
        wait_done("bp_done_seen");
        check("bp_count", 64'(log_nonce.size()), 64'd1);
`ifdef NONCE_SCHED_STATS_EN
        check("bp_stat_stall", 64'(stat_stall), 64'd5);
        check("bp_stat_issued", 64'(stat_issued), 64'd1);
`else
        check("bp_stat_stall", 64'(stat_stall), 64'd0);
        check("bp_stat_issued", 64'(stat_issued), 64'd0);
`endif

        // Preempt: job B offered in ARB while cores still request
        apply_reset();
        bus.core_req = 8'b0000_0011; bus.blob_ready = 1'b1;
        offer_job(pattern(5, 9), 32'h0, 32'd100);
        begin
            bit got = 1'b0;
            for (int n = 0; n < 50 && !got; n++) begin
                @(negedge aclk);
                if (log_nonce.size() >= 1) got = 1'b1;
            end
            check("pre_first_issue", 64'(got), 64'd1);
        end
        wait_valid("pre_second_valid");
        @(posedge aclk); #1;
        bus.job_blob = ~pattern(5, 9); bus.job_start_nonce = 32'h100; bus.job_count = 32'd1;
        bus.job_valid = 1'b1;
        @(posedge aclk); #1 bus.job_valid = 1'b0;
        wait_done("pre_done_seen");
        repeat (3) @(negedge aclk);
        check("pre_count", 64'(log_nonce.size()), 64'd3);
        if (log_nonce.size() == 3) begin
            check("pre_nonce_a1", 64'(log_nonce[1]), 64'h1);
            check("pre_nonce_b", 64'(log_nonce[2]), 64'h100);
            check("pre_core_b", 64'(log_oh[2]), 64'h01);
        end
        check("pre_done_count", 64'(done_cnt), 64'd1);

        // Zero count: done two cycles after the accept cycle, nothing issued
        apply_reset();
        bus.core_req = '1; bus.blob_ready = 1'b1;
        offer_job(pattern(2, 2), 32'h77, 32'd0);
        @(negedge aclk);
        check("zero_done_early", 64'(done), 64'd0);
        check("zero_busy", 64'(busy), 64'd1);
        @(negedge aclk);
        check("zero_done", 64'(done), 64'd1);
        @(negedge aclk);
        check("zero_done_pulse", 64'(done), 64'd0);
        check("zero_no_issue", 64'(log_nonce.size()), 64'd0);
        check("zero_no_valid", 64'(bus.blob_valid), 64'd0);

        // Reset asserted during ISSUE
        apply_reset();
        bus.core_req = 8'b0001_0000; bus.blob_ready = 1'b0;
        offer_job(pattern(1, 1), 32'h33, 32'd4);
        wait_valid("mid_valid_seen");
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.blob_valid), 64'd0);
        check("mid_rst_core", 64'(bus.blob_core_oh), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        bus.core_req = '0;
        repeat (2) @(posedge aclk);
        #1 rst_n = 1'b1;
        @(negedge aclk);
        check("mid_rel_job_ready", 64'(bus.job_ready), 64'd1);
        check("mid_rel_valid", 64'(bus.blob_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/nonce_scheduler.md
Name: nonce_scheduler

Overview:
- Sequences hashing work across CORE_COUNT cryptonight cores.
- Accepts one job: raw blob, start nonce and nonce count. Byte-reverses the blob and inserts a per-issue nonce.
- Round-robin arbitrates between cores requesting work and hands each granted core one blob+nonce over a shared registered output bus.
- Sits between the host job interface and the per-core input FIFOs. It replaces free-running nonce generation with explicit, bounded, preemptible scheduling.

Parameters:
- CORE_COUNT, 8, number of requesting cores (≥2).
- BLOB_WIDTH, 2144, blob width in bits (multiple of 8).
- NONCE_WIDTH, 32, nonce width in bits.
- NONCE_POS, 39, byte offset of the nonce in the byte-reversed blob.
- COUNT_WIDTH, 32, width of the job nonce-count field.

Ports:
- aclk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- job_valid  in  1  job offer.
- job_ready  out  1  job accepted when job_valid & job_ready.
- job_blob  in  BLOB_WIDTH  raw blob (host byte order).
- job_start_nonce  in  NONCE_WIDTH  first nonce.
- job_count  in  COUNT_WIDTH  number of nonces to issue.
- core_req  in  CORE_COUNT  level request per core.
- blob_valid  out  1  issue valid.
- blob_ready  in  1  downstream accepts the issue.
- blob_data  out  BLOB_WIDTH  reversed blob with nonce inserted.
- blob_nonce  out  NONCE_WIDTH  nonce carried in blob_data.
- blob_core_oh  out  CORE_COUNT  one-hot destination core.
- busy  out  1  job active (state ≠ IDLE).
- done  out  1  one-cycle pulse when the job count is exhausted.
- stat_issued  out  32  see Optional Feature.
- stat_stall  out  32  see Optional Feature.

Behaviour:
- Reset: async assert; all registers cleared. blob_valid=0, blob_data=0, blob_nonce=0, blob_core_oh=0, busy=0, done=0, rr pointer=0, state=IDLE. Reset mid-ISSUE drops the pending issue with no handshake.
- States: IDLE, ARB, ISSUE.
- IDLE:
  - job_ready=1.
  - On accept: latch blob, nonce=job_start_nonce, remaining=job_count; go to ARB.
- ARB (evaluated in this priority order):
  - job_ready=1.
  - (1) job_valid: preempt. Reload all job registers and stay in ARB. No done pulse for the aborted job.
  - (2) remaining==0: done=1 for one cycle; go to IDLE.
  - (3) any core_req bit set: grant the first requester at or after the rr pointer (circular). Register blob_data, blob_nonce and blob_core_oh; set blob_valid=1; go to ISSUE.
  - (4) otherwise stay in ARB.
- ISSUE:
  - job_ready=0. Outputs hold stable while blob_ready=0. Changes on core_req are ignored because the grant is committed.
  - On blob_valid & blob_ready: blob_valid=0, nonce+=1, remaining-=1, rr pointer=(granted index+1) mod CORE_COUNT; go to ARB.
- Nonce arithmetic: modulo 2^NONCE_WIDTH, wraps 0xFFFFFFFF→0. remaining never underflows.
- job_count=0: job is accepted, then done pulses on the next ARB cycle with zero issues.
- Latency:
  - Job accept to first possible grant: 1 cycle.
  - Grant to blob_valid: registered, same edge as the ARB→ISSUE transition.
  - Throughput: at most 1 issue per 2 cycles.
- blob_data format:
  - Byte-reverse job_blob: byte i moves to byte BLOB_WIDTH/8-1-i.
  - Then overwrite bits [NONCE_POS*8 +: NONCE_WIDTH] with the current nonce, in native bit order.
  - Other bits pass through unchanged.

Optional Feature:
- Macro: NONCE_SCHED_STATS_EN.
- Defined:
  - stat_issued counts output handshakes since reset.
  - stat_stall counts cycles with blob_valid & ~blob_ready.
  - Both are 32-bit, saturating at 0xFFFFFFFF, and reset to 0.
- Undefined: both ports are tied to 0 and no counter logic is built. The interface is unchanged.

Decomposition:
- Package nonce_sched_pkg:
  - state enum (IDLE/ARB/ISSUE);
  - localparam BLOB_BYTES;
  - function for the next round-robin index.
- Sub-module: nonce_insert. Combinational byte reversal plus nonce splice, parameterised by BLOB_WIDTH, NONCE_WIDTH and NONCE_POS. It is instantiated once, ahead of the blob_data register.

Test Plan:
- Reset: assert rst_n=0 mid-ISSUE → blob_valid, blob_core_oh, busy and done all 0 immediately. After release, job_ready=1.
- Basic round-robin: job start=0x10, count=3, core_req=0b0101, blob_ready=1 → issues (core0, 0x10), (core2, 0x11), (core0, 0x12), then done pulse, then busy=0.
- Wrap: start=0xFFFFFFFF, count=2, core_req=0b1 → nonces 0xFFFFFFFF then 0x00000000, each correctly placed at bits [312 +: 32] of blob_data.
- Backpressure: blob_ready=0 for 5 cycles during ISSUE, core_req dropped meanwhile → blob_data, blob_nonce and blob_core_oh stable; nonce does not advance until the handshake. With STATS_EN, stat_stall=5.
- Preempt: job A (start 0x0, count 100) after 2 issues; job B (start 0x100, count 1) offered in ARB together with core_req → job B accepted first. Next issue carries 0x100, then exactly one done pulse.
- Zero count: job_count=0 with core_req all 1 → no blob_valid; done pulses 2 cycles after accept.
